// File: rtl/madd_result_serializer.sv
// Result serializer: buffers DW-bit words from the multiply-add core in a small FIFO
// and streams each one out MSB nibble first over a narrow valid/ready port.
module madd_result_serializer #(
    parameter int DEPTH = 4,
    parameter int DW    = 12,
    parameter int NW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [NW-1:0]            out_nibble,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               words_sent
);
    localparam int NPW = DW / NW;
    localparam int AW  = $clog2(DEPTH);
    localparam int IW  = (NPW > 1) ? $clog2(NPW) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] sh_q, sh_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          vld_q, vld_d;
    logic [7:0]    ws_q, ws_d;

    logic push, accept, last_acc, load;

    assign in_ready   = (level_q != (AW+1)'(DEPTH));
    assign out_valid  = vld_q;
    // The shifter moves the current nibble into the top slot; it is all-zero when empty.
    assign out_nibble = sh_q[DW-1 -: NW];
    assign out_last   = vld_q && (idx_q == IW'(NPW-1));
    assign level      = level_q;
    assign words_sent = ws_q;

    assign push     = in_valid && in_ready && !clear;
    assign accept   = vld_q && out_ready && !clear;
    assign last_acc = accept && (idx_q == IW'(NPW-1));
    // Load only from words already in the FIFO: no same-cycle pass-through.
    assign load     = (!vld_q || last_acc) && (level_q != '0) && !clear;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        sh_d     = sh_q;
        idx_d    = idx_q;
        vld_d    = vld_q;
        ws_d     = ws_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            sh_d     = '0;
            idx_d    = '0;
            vld_d    = 1'b0;
            ws_d     = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (accept) begin
                sh_d  = sh_q << NW;
                idx_d = idx_q + 1'b1;
            end
            if (last_acc) begin
                vld_d = 1'b0;
                ws_d  = ws_q + 8'd1;
            end
            if (load) begin
                sh_d     = mem_q[rd_ptr_q];
                idx_d    = '0;
                vld_d    = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + (AW+1)'(push) - (AW+1)'(load);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sh_q     <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            ws_q     <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sh_q     <= sh_d;
            idx_q    <= idx_d;
            vld_q    <= vld_d;
            ws_q     <= ws_d;
        end
    end
endmodule

// File: tb/tb_madd_result_serializer.sv
// Scoreboard bench for madd_result_serializer: word/occupancy model plus a nibble queue,
// checked every cycle on the falling edge.
module tb_madd_result_serializer;
    localparam int DEPTH = 4;
    localparam int DW    = 12;
    localparam int NW    = 4;
    localparam int NPW   = DW / NW;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             clear = 0;
    logic             in_valid = 0;
    logic [DW-1:0]    in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [NW-1:0]    out_nibble;
    logic             out_last;
    logic             out_ready = 1;
    logic [2:0]       level;
    logic [7:0]       words_sent;

    madd_result_serializer #(.DEPTH(DEPTH), .DW(DW), .NW(NW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_nibble(out_nibble), .out_last(out_last),
        .out_ready(out_ready), .level(level), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    typedef struct { logic [NW-1:0] nib; bit last; } exp_t;
    exp_t q[$];

    int n_chk = 0, n_fail = 0;
    int m_fifo = 0;        // words waiting in the FIFO
    bit m_sh = 0;          // a word is being shifted out
    int m_ws = 0;
    bit prev_stall = 0;
    logic [NW-1:0] prev_nib = '0;
    logic prev_last = 0;
    bit done = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fifo = 0; m_sh = 0; m_ws = 0; prev_stall = 0;
    endtask

    // Monitor: compare against the model, then advance it with the inputs seen this cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit acc, lst, ld, psh;
            check("out_valid", int'(out_valid), int'(m_sh));
            check("level", int'(level), m_fifo);
            check("in_ready", int'(in_ready), int'(m_fifo != DEPTH));
            check("words_sent", int'(words_sent), m_ws);
            if (m_sh && q.size() > 0) begin
                check("out_nibble", int'(out_nibble), int'(q[0].nib));
                check("out_last", int'(out_last), int'(q[0].last));
            end else begin
                check("idle_nibble", int'(out_nibble), 0);
                check("idle_last", int'(out_last), 0);
            end
            if (prev_stall) begin
                check("hold_nibble", int'(out_nibble), int'(prev_nib));
                check("hold_last", int'(out_last), int'(prev_last));
            end
            prev_stall = m_sh && !out_ready && !clear;
            prev_nib   = out_nibble;
            prev_last  = out_last;
            if (clear) begin
                model_reset();
            end else begin
                acc = m_sh && out_ready;
                lst = acc && q.size() > 0 && q[0].last;
                if (acc && q.size() > 0) void'(q.pop_front());
                if (lst) m_ws = (m_ws + 1) % 256;
                psh = in_valid && (m_fifo != DEPTH);
                ld  = (!m_sh || lst) && m_fifo > 0;
                m_sh   = ld || (m_sh && !lst);
                m_fifo = m_fifo + int'(psh) - int'(ld);
                if (psh)
                    for (int k = 0; k < NPW; k++) begin
                        exp_t e;
                        e.nib  = NW'(in_data >> (DW - NW - k*NW));
                        e.last = (k == NPW-1);
                        q.push_back(e);
                    end
            end
        end
    end

    task automatic send(input logic [DW-1:0] w);
        bit ok = 0;
        in_valid = 1; in_data = w;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) check("push_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic drain(input int limit);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk); #1;
            ok = (q.size() == 0) && !out_valid;
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cycles(2);
        rst_n = 1;
        cycles(2);

        // single word
        send(12'hABC);
        drain(20);

        // back-to-back streaming
        send(12'h123); send(12'h456); send(12'h789);
        drain(30);

        // backpressure until full, then release
        out_ready = 0;
        fork
            for (int i = 1; i <= 6; i++) send(DW'(i));
            begin cycles(10); out_ready = 1; end
        join
        drain(60);

        // stall mid-word
        out_ready = 1;
        send(12'hF0E);
        out_ready = 0; cycles(1);
        out_ready = 0; cycles(1);
        out_ready = 1;
        drain(20);

        // clear mid-word with three words queued
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(DW'(12'h310 + i));
        cycles(1);
        out_ready = 1; cycles(1);
        out_ready = 0; clear = 1; cycles(1);
        clear = 0; cycles(3);
        out_ready = 1;

        // async reset mid-nibble
        send(12'h5A5);
        cycles(1);
        @(posedge clk); #2;
        rst_n = 0; #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_nibble", int'(out_nibble), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_level", int'(level), 0);
        check("rst_words_sent", int'(words_sent), 0);
        check("rst_in_ready", int'(in_ready), 1);
        cycles(2);
        rst_n = 1;
        cycles(2);

        // random traffic across the words_sent wrap
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    if ($urandom_range(0, 3) == 0) cycles(1);
                    send(DW'($urandom));
                end
                done = 1;
            end
            while (!done) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1;
        drain(100);
        check("wrap_words_sent", int'(words_sent), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
